// File: rtl/team_06_adc_pkg.sv
// Shared types and sizing helpers for the team_06 SPI ADC capture block.
package team_06_adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } adc_state_t;

  // Channel index width; a single channel still gets a 1-bit (always 0) tag.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/team_06_adc_capture.sv
// SPI ADC frame sequencer and deserializer with a round-robin channel tag and a
// one-word holding register. Define TEAM_06_ADC_TWOS_EN to flip each word's MSB.
module team_06_adc_capture
  import team_06_adc_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_CH    = 1,
  parameter int LEAD_BITS = 0,
  parameter int GAP_CYC   = 1,
  localparam int CH_W     = ch_width(NUM_CH)
) (
  input  logic              spiclk,
  input  logic              rst,
  input  logic              en,
  input  logic              adc_serial_in,
  output logic              adc_cs_n,
  output logic [CH_W-1:0]   ch_sel,
  output logic              busy,
  output logic [DATA_W-1:0] sample_data,
  output logic [CH_W-1:0]   sample_ch,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  input  logic              overrun_clr,
  output adc_state_t        state_dbg
);

  localparam int CNT_W = $clog2(max3(DATA_W, LEAD_BITS, GAP_CYC) + 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(LEAD_BITS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);
  localparam adc_state_t       FIRST_ST  = (LEAD_BITS == 0) ? SHIFT : LEAD;

  adc_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-2:0] shreg;
  logic [DATA_W-1:0] word_raw;
  logic [DATA_W-1:0] word_ld;
  logic [CH_W-1:0]   ch_next;

  assign word_raw = {shreg, adc_serial_in};

`ifdef TEAM_06_ADC_TWOS_EN
  assign word_ld = word_raw ^ {1'b1, {(DATA_W-1){1'b0}}};
`else
  assign word_ld = word_raw;
`endif

  assign ch_next   = (ch_sel == CH_LAST) ? '0 : ch_sel + CH_W'(1);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Handshake: a word transfers on any edge where sample_valid && sample_ready;
  // sample_valid never drops without a transfer, and a word completing while the
  // register is full and not being drained is dropped and flagged in overrun.
  always_ff @(posedge spiclk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      shreg        <= '0;
      adc_cs_n     <= 1'b1;
      ch_sel       <= '0;
      sample_data  <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (sample_valid && sample_ready) sample_valid <= 1'b0;
      if (overrun_clr) overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (en) begin
            adc_cs_n <= 1'b0;
            cnt      <= '0;
            state    <= FIRST_ST;
          end
        end
        LEAD: begin
          if (cnt == LEAD_LAST) begin
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SHIFT: begin
          shreg <= word_raw[DATA_W-2:0];
          if (cnt == DATA_LAST) begin
            cnt      <= '0;
            state    <= GAP;
            adc_cs_n <= 1'b1;
            ch_sel   <= ch_next;
            if (!sample_valid || sample_ready) begin
              sample_data  <= word_ld;
              sample_ch    <= ch_sel;
              sample_valid <= 1'b1;
            end else begin
              // Later assignment overrides a same-edge clear: set wins.
              overrun <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (en) begin
              adc_cs_n <= 1'b0;
              state    <= FIRST_ST;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_team_06_adc_capture.sv
// Directed bench: 8-bit single-channel instance and 12-bit, 3-channel, 2-lead-bit instance.
module tb_team_06_adc_capture;

  logic spiclk = 1'b0;
  logic rst;
  always #5 spiclk = ~spiclk;

  int n_chk  = 0;
  int n_fail = 0;

  // Instance A: DATA_W=8, NUM_CH=1, LEAD_BITS=0, GAP_CYC=1
  logic       a_en, a_sin, a_rdy, a_clr;
  logic       a_cs_n, a_busy, a_valid, a_ovr;
  logic [0:0] a_ch_sel, a_ch;
  logic [7:0] a_data;
  logic [1:0] a_st;

  // Instance B: DATA_W=12, NUM_CH=3, LEAD_BITS=2, GAP_CYC=2
  logic        b_en, b_sin, b_rdy, b_clr;
  logic        b_cs_n, b_busy, b_valid, b_ovr;
  logic [1:0]  b_ch_sel, b_ch;
  logic [11:0] b_data;
  logic [1:0]  b_st;

  team_06_adc_capture #(.DATA_W(8), .NUM_CH(1), .LEAD_BITS(0), .GAP_CYC(1)) u_a (
    .spiclk(spiclk), .rst(rst), .en(a_en), .adc_serial_in(a_sin),
    .adc_cs_n(a_cs_n), .ch_sel(a_ch_sel), .busy(a_busy),
    .sample_data(a_data), .sample_ch(a_ch), .sample_valid(a_valid),
    .sample_ready(a_rdy), .overrun(a_ovr), .overrun_clr(a_clr),
    .state_dbg(a_st)
  );

  team_06_adc_capture #(.DATA_W(12), .NUM_CH(3), .LEAD_BITS(2), .GAP_CYC(2)) u_b (
    .spiclk(spiclk), .rst(rst), .en(b_en), .adc_serial_in(b_sin),
    .adc_cs_n(b_cs_n), .ch_sel(b_ch_sel), .busy(b_busy),
    .sample_data(b_data), .sample_ch(b_ch), .sample_valid(b_valid),
    .sample_ready(b_rdy), .overrun(b_ovr), .overrun_clr(b_clr),
    .state_dbg(b_st)
  );

  function automatic logic [7:0] cv8(input logic [7:0] x);
`ifdef TEAM_06_ADC_TWOS_EN
    x[7] = ~x[7];
`endif
    return x;
  endfunction

  function automatic logic [11:0] cv12(input logic [11:0] x);
`ifdef TEAM_06_ADC_TWOS_EN
    x[11] = ~x[11];
`endif
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge after the frame-start edge; returns at the negedge after the LSB edge.
  task automatic send_a(input logic [7:0] w, input logic clr_last);
    for (int i = 7; i >= 0; i--) begin
      check("a_cs_low", 32'(a_cs_n), 32'd0);
      a_sin = w[i];
      if (i == 0) a_clr = clr_last;
      @(negedge spiclk);
    end
    a_clr = 1'b0;
  endtask

  task automatic send_b(input logic [11:0] w);
    for (int i = 0; i < 2; i++) begin
      check("b_cs_low_lead", 32'(b_cs_n), 32'd0);
      b_sin = 1'($urandom_range(0, 1));
      @(negedge spiclk);
    end
    for (int i = 11; i >= 0; i--) begin
      check("b_cs_low", 32'(b_cs_n), 32'd0);
      b_sin = w[i];
      @(negedge spiclk);
    end
  endtask

  logic [11:0] b_words [4];
  logic [1:0]  b_chs   [4];

  initial begin
    rst = 1'b0;
    a_en = 1'b0; a_sin = 1'b0; a_rdy = 1'b1; a_clr = 1'b0;
    b_en = 1'b0; b_sin = 1'b0; b_rdy = 1'b1; b_clr = 1'b0;
    b_words = '{12'h800, 12'h7FF, 12'hA5C, 12'h123};
    b_chs   = '{2'd0, 2'd1, 2'd2, 2'd0};

    repeat (3) @(negedge spiclk);
    check("rst_a_cs_n",  32'(a_cs_n),   32'd1);
    check("rst_a_busy",  32'(a_busy),   32'd0);
    check("rst_a_data",  32'(a_data),   32'd0);
    check("rst_a_valid", 32'(a_valid),  32'd0);
    check("rst_a_ovr",   32'(a_ovr),    32'd0);
    check("rst_a_state", 32'(a_st),     32'd0);
    check("rst_b_ch_sel", 32'(b_ch_sel), 32'd0);
    check("rst_b_ch",    32'(b_ch),     32'd0);

    // Single frame, ready high
    rst = 1'b1;
    a_en = 1'b1;
    @(negedge spiclk);
    check("a_busy_start", 32'(a_busy), 32'd1);
    send_a(8'hA7, 1'b0);
    check("t1_valid", 32'(a_valid), 32'd1);
    check("t1_data",  32'(a_data),  32'(cv8(8'hA7)));
    check("t1_ch",    32'(a_ch),    32'd0);
    check("t1_cs_hi", 32'(a_cs_n),  32'd1);
    check("t1_ovr",   32'(a_ovr),   32'd0);
    @(negedge spiclk);
    check("t1_pulse", 32'(a_valid), 32'd0);
    check("t1_next_cs", 32'(a_cs_n), 32'd0);

    // Back-to-back frame
    send_a(8'hD6, 1'b0);
    check("t2_valid", 32'(a_valid), 32'd1);
    check("t2_data",  32'(a_data),  32'(cv8(8'hD6)));
    check("t2_ovr",   32'(a_ovr),   32'd0);
    @(negedge spiclk);
    check("t2_pulse", 32'(a_valid), 32'd0);

    // Consumer stalled across two frames
    a_rdy = 1'b0;
    send_a(8'hA7, 1'b0);
    check("t3_valid1", 32'(a_valid), 32'd1);
    check("t3_data1",  32'(a_data),  32'(cv8(8'hA7)));
    check("t3_ovr1",   32'(a_ovr),   32'd0);
    @(negedge spiclk);
    send_a(8'hD6, 1'b0);
    check("t3_data2", 32'(a_data),  32'(cv8(8'hA7)));
    check("t3_valid2", 32'(a_valid), 32'd1);
    check("t3_ovr2",  32'(a_ovr),   32'd1);
    a_clr = 1'b1;
    @(negedge spiclk);
    a_clr = 1'b0;
    check("t3_ovr_clr", 32'(a_ovr), 32'd0);
    // Clear and a fresh overrun on the same edge
    send_a(8'h5A, 1'b1);
    check("t3_set_wins", 32'(a_ovr),  32'd1);
    check("t3_data3",    32'(a_data), 32'(cv8(8'hA7)));
    a_en = 1'b0;
    a_rdy = 1'b1;
    @(negedge spiclk);
    check("t3_drain",  32'(a_valid), 32'd0);
    check("t3_idle",   32'(a_busy),  32'd0);
    check("t3_cs_idle", 32'(a_cs_n), 32'd1);
    check("t3_sticky", 32'(a_ovr),   32'd1);
    a_clr = 1'b1;
    @(negedge spiclk);
    a_clr = 1'b0;
    check("t3_ovr_clr2", 32'(a_ovr), 32'd0);
    check("t3_stay_idle", 32'(a_busy), 32'd0);

    // Reset at bit 4 of a frame
    a_en = 1'b1;
    @(negedge spiclk);
    for (int i = 7; i >= 4; i--) begin
      a_sin = 1'b1;
      @(negedge spiclk);
    end
    check("t5_busy_pre", 32'(a_busy), 32'd1);
    rst = 1'b0;
    #1;
    check("t5_cs_n",  32'(a_cs_n),  32'd1);
    check("t5_busy",  32'(a_busy),  32'd0);
    check("t5_data",  32'(a_data),  32'd0);
    check("t5_valid", 32'(a_valid), 32'd0);
    check("t5_state", 32'(a_st),    32'd0);
    @(negedge spiclk);
    rst = 1'b1;
    @(negedge spiclk);
    send_a(8'h3C, 1'b0);
    check("t5_clean_data",  32'(a_data),  32'(cv8(8'h3C)));
    check("t5_clean_valid", 32'(a_valid), 32'd1);
    a_en = 1'b0;
    @(negedge spiclk);

    // Multichannel, lead bits, 12-bit words
    b_en = 1'b1;
    @(negedge spiclk);
    for (int f = 0; f < 4; f++) begin
      send_b(b_words[f]);
      check("t4_valid",  32'(b_valid),  32'd1);
      check("t4_data",   32'(b_data),   32'(cv12(b_words[f])));
      check("t4_ch",     32'(b_ch),     32'(b_chs[f]));
      check("t4_ch_sel", 32'(b_ch_sel), 32'((b_chs[f] + 1) % 3));
      check("t4_cs_hi",  32'(b_cs_n),   32'd1);
      if (f == 3) b_en = 1'b0;
      @(negedge spiclk);
      check("t4_gap_cs", 32'(b_cs_n), 32'd1);
      @(negedge spiclk);
    end
    check("t4_idle", 32'(b_busy), 32'd0);
    check("t4_ovr",  32'(b_ovr),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
